// File: rtl/echo_feedback_processor.sv
// Echo delay-line processing stage: decay and wet-mix products on one
// shared multiplier, saturating sums, valid/ready on both sides.
module echo_feedback_processor #(
  parameter int sample_width = 16,
  parameter int gain_width   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [sample_width-1:0] i_current,
  input  logic [sample_width-1:0] i_buffer,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [sample_width-1:0] o_current,
  output logic [sample_width-1:0] o_feedback,
  input  logic [gain_width-1:0]   cfg_decay,
  input  logic [gain_width-1:0]   cfg_mix,
  input  logic                    cfg_bypass,
  output logic                    busy
);

  localparam int pw = sample_width + gain_width + 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL_DECAY,
    MUL_MIX,
    SUM,
    OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [sample_width-1:0] cur_q;
  logic signed [sample_width-1:0] buf_q;
  logic [gain_width-1:0]          decay_q;
  logic [gain_width-1:0]          mix_q;
  logic                           byp_q;
  logic signed [sample_width-1:0] p_decay;
  logic signed [sample_width-1:0] p_mix;

  logic [gain_width-1:0]          gain_sel;
  logic signed [pw-1:0]           prod;
  logic signed [sample_width-1:0] mul_res;
  logic                           unused_prod;
  logic signed [sample_width:0]   sum_fb;
  logic signed [sample_width:0]   sum_wet;

  // Clamp a one-bit-wider sum back into the sample range.
  function automatic logic [sample_width-1:0] sat(
    input logic [sample_width:0] s
  );
    if (s[sample_width] != s[sample_width-1])
      sat = s[sample_width]
          ? {1'b1, {(sample_width-1){1'b0}}}
          : {1'b0, {(sample_width-1){1'b1}}};
    else
      sat = s[sample_width-1:0];
  endfunction

  // The single multiplier; gain operand chosen by sequencer state.
  assign gain_sel = (state == MUL_MIX) ? mix_q : decay_q;
  assign prod     = buf_q * $signed({1'b0, gain_sel});
  // Taking the upper bits is an arithmetic shift, i.e. floor.
  // |buf * g| < 2^(pw-2), so the top bit is only a sign copy.
  assign mul_res  = prod[gain_width +: sample_width];
  assign unused_prod = ^{prod[pw-1], prod[gain_width-1:0]};

  assign sum_fb  = {cur_q[sample_width-1], cur_q}
                 + {p_decay[sample_width-1], p_decay};
  assign sum_wet = {cur_q[sample_width-1], cur_q}
                 + {p_mix[sample_width-1], p_mix};

  assign i_ready = (state == IDLE);
  assign o_valid = (state == OUT);
  assign busy    = (state != IDLE);

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: fixed walk through the products, wait on handshakes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (i_valid) state_nxt = MUL_DECAY;
      MUL_DECAY: state_nxt = MUL_MIX;
      MUL_MIX:   state_nxt = SUM;
      SUM:       state_nxt = OUT;
      OUT:       if (o_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Datapath: shadow capture, products, saturated results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q      <= '0;
      buf_q      <= '0;
      decay_q    <= '0;
      mix_q      <= '0;
      byp_q      <= 1'b0;
      p_decay    <= '0;
      p_mix      <= '0;
      o_current  <= '0;
      o_feedback <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            cur_q   <= i_current;
            buf_q   <= i_buffer;
            decay_q <= cfg_decay;
            mix_q   <= cfg_mix;
            byp_q   <= cfg_bypass;
          end
        end
        MUL_DECAY: p_decay <= mul_res;
        MUL_MIX:   p_mix   <= mul_res;
        SUM: begin
          if (byp_q) begin
            o_current  <= cur_q;
            o_feedback <= '0;
          end else begin
            o_current  <= sat(sum_wet);
            o_feedback <= sat(sum_fb);
          end
        end
        OUT: ;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/echo_feedback_processor.md
# echo_feedback_processor

Processing stage for the echo delay line: implements the processor side of the delay buffer's handshake, taking the live sample and the delayed sample, and returning the output sample and the value to write back into the buffer. A single shared multiplier is time-multiplexed over the decay (feedback) and mix (wet) products by a small sequencer. Gain configuration is sampled once per sample, so software or top-level controls can change it at any time without glitching a sample in flight.

## Interface
- sample_width, 16, signed two's-complement audio sample width
- gain_width, 8, unsigned gain width; gain value g means g / 2^gain_width (0 to just under 1.0)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0); one clock, reset asynchronous and active-low
- i_valid  in  1  sample pair valid (from buffer o_valid_processor)
- i_ready  out  1  ready to accept pair (to buffer o_ready_processor)
- i_current  in  sample_width  live input sample
- i_buffer  in  sample_width  delayed sample read from buffer
- o_valid  out  1  result valid (to buffer i_valid_processor)
- o_ready  in  1  result accepted (from buffer i_ready_processor)
- o_current  out  sample_width  output (wet) sample
- o_feedback  out  sample_width  sample to write back into buffer
- cfg_decay  in  gain_width  feedback gain
- cfg_mix  in  gain_width  wet mix gain
- cfg_bypass  in  1  1 = pass i_current through, write 0 into buffer
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, MUL_DECAY, MUL_MIX, SUM, OUT.
- IDLE: i_ready=1. On i_valid && i_ready: capture i_current, i_buffer, cfg_decay, cfg_mix, cfg_bypass into shadow registers; i_ready<=0; -> MUL_DECAY.
- MUL_DECAY: p_decay <= (buf * decay) >>> gain_width; signed buf times zero-extended gain, product width sample_width+gain_width+1, arithmetic shift (floor, not truncate-toward-zero). -> MUL_MIX.
- MUL_MIX: p_mix <= (buf * mix) >>> gain_width, same multiplier instance, operand mux selected by state. -> SUM.
- SUM: o_feedback <= sat(cur + p_decay); o_current <= sat(cur + p_mix); sums one bit wider than sample_width, saturated to [-2^(sample_width-1), 2^(sample_width-1)-1]. If bypass: o_current <= cur, o_feedback <= 0. o_valid<=1; -> OUT.
- OUT: o_current/o_feedback held stable. On o_ready: o_valid<=0, i_ready<=1; -> IDLE.
- Exactly one multiplier in the design; no combinational path from any input to any output.
- cfg_* changes while busy affect only the next accepted sample.

## Timing
- Reset values: i_ready=1, o_valid=0, o_current=0, o_feedback=0, busy=0, state=IDLE, all shadow/product registers 0.
- Accept at edge N -> o_valid high after edge N+3 (3-cycle latency); with o_ready already high, i_ready returns high after edge N+4. Minimum period 5 cycles per sample.
- i_valid while not ready is ignored; the pair must be held by the source (buffer holds until its handshake completes).
- o_ready low in OUT: stall indefinitely, outputs stable.
- Gain 0: product 0 -> feedback = output = cur. Gain 2^gain_width-1 with buf=-1: product floors to -1.
- Reset asserted mid-sample (any state): immediate return to reset values; the in-flight sample is discarded; the delay buffer shares this reset, so no half-completed handshake survives.
- Reset deassertion is synchronised externally; first acceptance possible on first edge after release.

## Test plan
- Nominal: cur=1000, buf=2000, decay=128, mix=64 (gain_width 8) -> o_feedback=2000, o_current=1500, o_valid 3 cycles after accept.
- Positive saturation: cur=30000, buf=30000, decay=255 -> p_decay=29882, o_feedback=32767; mix=0 -> o_current=30000.
- Negative saturation and floor: cur=-30000, buf=-30000, mix=255 -> p_mix=-29883, o_current=-32768; buf=-1, decay=255, cur=0 -> o_feedback=-1.
- Bypass and backpressure: cfg_bypass=1, cur=-1234, buf=5000, o_ready held low 10 cycles -> o_current=-1234, o_feedback=0 stable throughout, i_ready low until cycle after o_ready.
- Config change in flight: accept with decay=128, change to 0 in MUL_DECAY -> result uses 128; next sample uses 0.
- Reset mid-operation: reset low in MUL_MIX -> all outputs at reset values immediately; after release, fresh sample processes correctly.
